// File: rtl/mac_block_accumulator_if.sv
// rtl/mac_block_accumulator_if.sv - sample input and block-sum output handshake bundle
interface mac_block_accumulator_if #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 20
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sat;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/mac_block_accumulator.sv
// rtl/mac_block_accumulator.sv - saturating block accumulator over ACC_LEN samples
module mac_block_accumulator #(
  parameter int IN_WIDTH  = 18,
  parameter int ACC_LEN   = 4,
  parameter int OUT_WIDTH = 20,
  localparam int CNT_W    = $clog2(ACC_LEN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  mac_block_accumulator_if.slave bus,
  output logic [CNT_W-1:0]      sample_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  state_t               state, state_nxt;
  logic [OUT_WIDTH-1:0] acc;
  logic                 sat_sticky;
  logic [OUT_WIDTH:0]   sum;
  logic [OUT_WIDTH-1:0] sum_sat;
  logic                 clamp;
  logic                 last;
  logic                 in_fire;
  logic                 out_fire;

  assign last     = (sample_cnt == LAST_CNT);
  // The completing sample is held off while the previous sum is still pending.
  assign bus.in_ready = reset_n & ~clear & ~((state == FULL) & last);
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  assign sum     = {1'b0, acc} + {{(OUT_WIDTH + 1 - IN_WIDTH){1'b0}}, bus.in_data};
  assign clamp   = sum[OUT_WIDTH];
  assign sum_sat = clamp ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_fire && last) state_nxt = FULL;
      FULL:    if (out_fire)        state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      sample_cnt   <= '0;
      sat_sticky   <= 1'b0;
      bus.out_data <= '0;
      bus.out_sat  <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      sample_cnt <= '0;
      sat_sticky <= 1'b0;
    end else if (in_fire) begin
      if (last) begin
        bus.out_data <= sum_sat;
        bus.out_sat  <= sat_sticky | clamp;
        acc          <= '0;
        sample_cnt   <= '0;
        sat_sticky   <= 1'b0;
      end else begin
        acc        <= sum_sat;
        sample_cnt <= sample_cnt + CNT_W'(1);
        sat_sticky <= sat_sticky | clamp;
      end
    end
  end
endmodule
